// File: rtl/cpu_pkg.sv
// Shared definitions for the MCS8 bus-cycle sequencer.
//   cycle_t  : machine-cycle type presented by the core's cycle control
//   state_t  : external T-state codes, as they appear on STATE_O
//   is_write : true for cycles that drive data in T3 (PCW, PCC)
package cpu_pkg;

  typedef enum logic [1:0] {
    CYCLE_PCI = 2'b00,
    CYCLE_PCC = 2'b01,
    CYCLE_PCR = 2'b10,
    CYCLE_PCW = 2'b11
  } cycle_t;

  typedef enum logic [2:0] {
    ST_WAIT = 3'b000,
    ST_T3   = 3'b001,
    ST_T1   = 3'b010,
    ST_STOP = 3'b011,
    ST_T2   = 3'b100,
    ST_IDLE = 3'b110
  } state_t;

  function automatic logic is_write(input cycle_t c);
    return (c == CYCLE_PCW) || (c == CYCLE_PCC);
  endfunction

endpackage

// File: rtl/cpu_bus_seq_if.sv
// Request and external-bus signal bundle for cpu_bus_seq.
//   Request side : REQ_I, CYCLE_I, ADDR_I, WDATA_I -> REQ_RDY_O, ACK_O, RDATA_O
//   Control      : HALT_I, READY_I
//   External bus : DATA_I -> DATA_O, DATA_OE_O, SYNC_O, STATE_O
// slave is the sequencer's view; master is the core/bus environment's view.
interface cpu_bus_seq_if;

  logic        REQ_I;
  logic [1:0]  CYCLE_I;
  logic [13:0] ADDR_I;
  logic [7:0]  WDATA_I;
  logic        REQ_RDY_O;
  logic        ACK_O;
  logic [7:0]  RDATA_O;
  logic        HALT_I;
  logic        READY_I;
  logic [7:0]  DATA_I;
  logic [7:0]  DATA_O;
  logic        DATA_OE_O;
  logic        SYNC_O;
  logic [2:0]  STATE_O;

  modport slave (
    input  REQ_I, CYCLE_I, ADDR_I, WDATA_I, HALT_I, READY_I, DATA_I,
    output REQ_RDY_O, ACK_O, RDATA_O, DATA_O, DATA_OE_O, SYNC_O, STATE_O
  );

  modport master (
    output REQ_I, CYCLE_I, ADDR_I, WDATA_I, HALT_I, READY_I, DATA_I,
    input  REQ_RDY_O, ACK_O, RDATA_O, DATA_O, DATA_OE_O, SYNC_O, STATE_O
  );

endinterface

// File: rtl/cpu_bus_phase.sv
// Phase counter for the bus T-states.
//   clk, rstN  : clock, asynchronous active-low reset
//   active     : sequencer is in T1/T2/WAIT/T3
//   endOfState : last phase of the current T-state
//   sync       : high in phase 0 of an active T-state
// Every state change happens at end of state, so wrapping to 0 there is the
// same as clearing on state change.
module cpu_bus_phase #(
  parameter int unsigned PHASES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic active,
  output logic endOfState,
  output logic sync
);

  localparam int unsigned W = (PHASES > 2) ? 2 : 1;
  localparam logic [W-1:0] LAST = W'(PHASES - 1);

  logic [W-1:0] phase;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                      phase <= '0;
    else if (active && !endOfState) phase <= phase + 1'b1;
    else                            phase <= '0;
  end

  assign endOfState = active && (phase == LAST);
  assign sync       = active && (phase == '0);

endmodule

// File: rtl/cpu_bus_seq.sv
// MCS8 bus-cycle sequencer: runs T1, T2, optional WAIT, T3 for one accepted
// machine-cycle request, returns read data with a one-clock ACK, and owns the
// STOPPED state and SYNC.
//   CLK_I, nRST_I : clock, asynchronous active-low reset
//   bus (slave)   : request/ack, halt/ready and external multiplexed bus
module cpu_bus_seq
  import cpu_pkg::*;
#(
  parameter int unsigned PHASES = 2
) (
  input logic          CLK_I,
  input logic          nRST_I,
  cpu_bus_seq_if.slave bus
);

  state_t      state;
  state_t      stateNext;
  cycle_t      cycle;
  logic [13:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;
  logic        active;
  logic        endOfState;
  logic        endT3;
  logic        reqRdy;
  logic        accept;
  logic [7:0]  dataOut;
  logic        dataOe;

  assign active = state inside {ST_T1, ST_T2, ST_WAIT, ST_T3};
  assign endT3  = (state == ST_T3) && endOfState;

  // IDLE accepts even with HALT_I high so a simultaneous request wins; the
  // halt is then taken at that cycle's completion.
  assign reqRdy = (state == ST_IDLE) || endT3;
  assign accept = bus.REQ_I && reqRdy;

  cpu_bus_phase #(.PHASES(PHASES)) uPhase (
    .clk        (CLK_I),
    .rstN       (nRST_I),
    .active     (active),
    .endOfState (endOfState),
    .sync       (bus.SYNC_O)
  );

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) state <= ST_IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      cycle <= CYCLE_PCI;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      ack   <= 1'b0;
    end else begin
      ack <= endT3;
      if (accept) begin
        cycle <= cycle_t'(bus.CYCLE_I);
        addr  <= bus.ADDR_I;
        wdata <= bus.WDATA_I;
      end
      if (endT3 && !is_write(cycle)) rdata <= bus.DATA_I;
    end
  end

  always_comb begin
    stateNext = state;
    dataOut   = '0;
    dataOe    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept)          stateNext = ST_T1;
        else if (bus.HALT_I) stateNext = ST_STOP;
      end
      ST_T1: begin
        dataOut = addr[7:0];
        dataOe  = 1'b1;
        if (endOfState) stateNext = ST_T2;
      end
      ST_T2: begin
        dataOut = {cycle, addr[13:8]};
        dataOe  = 1'b1;
        if (endOfState) stateNext = bus.READY_I ? ST_T3 : ST_WAIT;
      end
      ST_WAIT: begin
        if (endOfState && bus.READY_I) stateNext = ST_T3;
      end
      ST_T3: begin
        if (is_write(cycle)) begin
          dataOut = wdata;
          dataOe  = 1'b1;
        end
        if (endOfState) begin
          if (accept)          stateNext = ST_T1;
          else if (bus.HALT_I) stateNext = ST_STOP;
          else                 stateNext = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (!bus.HALT_I) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign bus.REQ_RDY_O = reqRdy;
  assign bus.ACK_O     = ack;
  assign bus.RDATA_O   = rdata;
  assign bus.DATA_O    = dataOut;
  assign bus.DATA_OE_O = dataOe;
  assign bus.STATE_O   = state;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Self-checking bench for cpu_bus_seq: directed scenarios plus randomized
// cycles, checked clock-by-clock against a timeline model of the T-states.
module tb_cpu_bus_seq;

  localparam int unsigned P = 2;

  localparam logic [2:0] S_T1   = 3'b010;
  localparam logic [2:0] S_T2   = 3'b100;
  localparam logic [2:0] S_WAIT = 3'b000;
  localparam logic [2:0] S_T3   = 3'b001;
  localparam logic [2:0] S_STOP = 3'b011;
  localparam logic [2:0] S_IDLE = 3'b110;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  cpu_bus_seq_if bus();

  cpu_bus_seq #(.PHASES(P)) dut (
    .CLK_I  (clk),
    .nRST_I (rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] mRdata = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] cyc, input logic [13:0] addr, input logic [7:0] wd);
    bus.REQ_I   = 1'b1;
    bus.CYCLE_I = cyc;
    bus.ADDR_I  = addr;
    bus.WDATA_I = wd;
  endtask

  // Walks clocks t = 0 .. nClk-1 of a cycle whose T1 starts at t = 0.
  // A cycle with w wait states lasts (3+w)*P clocks; READY_I only matters on
  // the last clock of T2 and of each WAIT, so it is random elsewhere.
  task automatic runCycle(input logic [1:0] cyc, input logic [13:0] addr, input logic [7:0] wd,
                          input logic [7:0] din, input int w, input bit ackStart,
                          input bit chain, input logic [1:0] nCyc, input logic [13:0] nAddr,
                          input logic [7:0] nWd, input int haltAt, input int nClk);
    int L;
    bit wr;
    L  = (3 + w) * P;
    wr = (cyc == 2'b01) || (cyc == 2'b11);
    for (int t = 0; t < nClk; t++) begin
      int seg;
      logic [2:0] st;
      logic oe;
      logic [7:0] dOut;
      seg = t / P;
      if (seg == 0)          begin st = S_T1;   oe = 1'b1; dOut = addr[7:0]; end
      else if (seg == 1)     begin st = S_T2;   oe = 1'b1; dOut = {cyc, addr[13:8]}; end
      else if (seg < 2 + w)  begin st = S_WAIT; oe = 1'b0; dOut = '0; end
      else                   begin st = S_T3;   oe = wr;   dOut = wr ? wd : 8'h00; end
      @(negedge clk);
      check("state",  16'(bus.STATE_O),   16'(st));
      check("dataOe", 16'(bus.DATA_OE_O), 16'(oe));
      if (oe) check("dataOut", 16'(bus.DATA_O), 16'(dOut));
      check("sync",   16'(bus.SYNC_O),    16'(t % P == 0));
      check("ack",    16'(bus.ACK_O),     16'((t == 0) && ackStart));
      check("reqRdy", 16'(bus.REQ_RDY_O), 16'(t == L - 1));
      check("rdata",  16'(bus.RDATA_O),   16'(mRdata));
      bus.DATA_I = (t == L - 1) ? din : 8'($urandom);
      if ((t % P == P - 1) && seg >= 1) bus.READY_I = (seg - 1 == w);
      else                              bus.READY_I = 1'($urandom);
      if (t == L - 1) begin
        bus.REQ_I   = chain;
        bus.CYCLE_I = nCyc;
        bus.ADDR_I  = nAddr;
        bus.WDATA_I = nWd;
      end else begin
        bus.REQ_I   = 1'($urandom);
        bus.CYCLE_I = 2'($urandom);
        bus.ADDR_I  = 14'($urandom);
        bus.WDATA_I = 8'($urandom);
      end
      if (t == haltAt) bus.HALT_I = 1'b1;
    end
  endtask

  task automatic finishAck(input logic [2:0] st);
    @(negedge clk);
    check("ackEnd",    16'(bus.ACK_O),     16'(1));
    check("stateEnd",  16'(bus.STATE_O),   16'(st));
    check("rdataEnd",  16'(bus.RDATA_O),   16'(mRdata));
    check("oeEnd",     16'(bus.DATA_OE_O), 16'(0));
    check("syncEnd",   16'(bus.SYNC_O),    16'(0));
    check("reqRdyEnd", 16'(bus.REQ_RDY_O), 16'(st == S_IDLE));
    bus.REQ_I = 1'b0;
  endtask

  logic [1:0]  cc, nc;
  logic [13:0] ca, na;
  logic [7:0]  cw, nw, cd;
  int          cwt;
  bit          ch, ackS;

  initial begin
    bus.REQ_I   = 1'b0;
    bus.CYCLE_I = '0;
    bus.ADDR_I  = '0;
    bus.WDATA_I = '0;
    bus.HALT_I  = 1'b0;
    bus.READY_I = 1'b1;
    bus.DATA_I  = '0;

    // Reset held, then released
    repeat (3) @(negedge clk);
    check("rstState",  16'(bus.STATE_O),   16'(S_IDLE));
    check("rstOe",     16'(bus.DATA_OE_O), 16'(0));
    check("rstAck",    16'(bus.ACK_O),     16'(0));
    check("rstRdata",  16'(bus.RDATA_O),   16'(0));
    check("rstSync",   16'(bus.SYNC_O),    16'(0));
    check("rstReqRdy", 16'(bus.REQ_RDY_O), 16'(1));
    rstN = 1'b1;
    @(negedge clk);
    check("idleState",  16'(bus.STATE_O),   16'(S_IDLE));
    check("idleReqRdy", 16'(bus.REQ_RDY_O), 16'(1));

    // PCR read, no wait
    issue(2'b10, 14'h2A5C, 8'h00);
    runCycle(2'b10, 14'h2A5C, 8'h00, 8'h3C, 0, 1'b0, 1'b0, 2'b00, 14'h0, 8'h0, -1, 3 * P);
    mRdata = 8'h3C;
    finishAck(S_IDLE);

    // PCW with three wait states; RDATA untouched
    issue(2'b11, 14'h1234, 8'h81);
    runCycle(2'b11, 14'h1234, 8'h81, 8'hEE, 3, 1'b0, 1'b0, 2'b00, 14'h0, 8'h0, -1, 6 * P);
    finishAck(S_IDLE);

    // Back-to-back: PCR then PCI at 0x0001 with no idle gap
    issue(2'b10, 14'h0F0F, 8'h00);
    runCycle(2'b10, 14'h0F0F, 8'h00, 8'hA5, 0, 1'b0, 1'b1, 2'b00, 14'h0001, 8'h00, -1, 3 * P);
    mRdata = 8'hA5;
    runCycle(2'b00, 14'h0001, 8'h00, 8'h5A, 1, 1'b1, 1'b0, 2'b00, 14'h0, 8'h0, -1, 4 * P);
    mRdata = 8'h5A;
    finishAck(S_IDLE);

    // HALT raised in T2 of a PCI: cycle completes, then STOPPED
    issue(2'b00, 14'h3FFF, 8'h00);
    runCycle(2'b00, 14'h3FFF, 8'h00, 8'hC3, 0, 1'b0, 1'b0, 2'b00, 14'h0, 8'h0, P, 3 * P);
    mRdata = 8'hC3;
    finishAck(S_STOP);
    for (int i = 0; i < 3; i++) begin
      bus.REQ_I   = 1'b1;
      bus.CYCLE_I = 2'($urandom);
      bus.ADDR_I  = 14'($urandom);
      @(negedge clk);
      check("stopState",  16'(bus.STATE_O),   16'(S_STOP));
      check("stopReqRdy", 16'(bus.REQ_RDY_O), 16'(0));
      check("stopAck",    16'(bus.ACK_O),     16'(0));
    end
    bus.HALT_I = 1'b0;
    @(negedge clk);
    check("unhaltState", 16'(bus.STATE_O), 16'(S_IDLE));
    bus.REQ_I = 1'b0;

    // HALT from IDLE
    bus.HALT_I = 1'b1;
    @(negedge clk);
    check("idleHalt", 16'(bus.STATE_O), 16'(S_STOP));
    bus.HALT_I = 1'b0;
    @(negedge clk);
    check("idleUnhalt", 16'(bus.STATE_O), 16'(S_IDLE));

    // Randomized cycles, some chained back-to-back
    ackS = 1'b0;
    cc = 2'($urandom); ca = 14'($urandom); cw = 8'($urandom);
    issue(cc, ca, cw);
    for (int i = 0; i < 24; i++) begin
      nc  = 2'($urandom);
      na  = 14'($urandom);
      nw  = 8'($urandom);
      cd  = 8'($urandom);
      cwt = int'($urandom_range(0, 3));
      ch  = (i != 23) && ($urandom_range(0, 1) == 1);
      runCycle(cc, ca, cw, cd, cwt, ackS, ch, nc, na, nw, -1, (3 + cwt) * P);
      if (cc == 2'b00 || cc == 2'b10) mRdata = cd;
      if (ch) ackS = 1'b1;
      else begin
        finishAck(S_IDLE);
        ackS = 1'b0;
        if (i != 23) issue(nc, na, nw);
      end
      cc = nc; ca = na; cw = nw;
    end

    // Reset pulsed during T3 of a PCW: bus released, no ACK
    issue(2'b11, 14'h2222, 8'h77);
    runCycle(2'b11, 14'h2222, 8'h77, 8'h00, 0, 1'b0, 1'b0, 2'b00, 14'h0, 8'h0, -1, 2 * P + 1);
    bus.REQ_I = 1'b0;
    #1 rstN = 1'b0;
    #1;
    mRdata = 8'h00;
    check("midRstState", 16'(bus.STATE_O),   16'(S_IDLE));
    check("midRstOe",    16'(bus.DATA_OE_O), 16'(0));
    check("midRstAck",   16'(bus.ACK_O),     16'(0));
    check("midRstRdata", 16'(bus.RDATA_O),   16'(mRdata));
    repeat (2) begin
      @(negedge clk);
      check("rstHoldAck", 16'(bus.ACK_O), 16'(0));
    end
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postRstAck",   16'(bus.ACK_O),   16'(0));
      check("postRstState", 16'(bus.STATE_O), 16'(S_IDLE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
